// File: rtl/led_shift_sequencer.sv
// Command-driven sequencer for an 8-bit circular LED shift register:
// a prescaled base tick, a programmable step period and a stop/run motion FSM.
module led_shift_sequencer #(
    parameter int unsigned CLK_FREQ      = 25_000_000,
    parameter int unsigned TICK_DIV      = CLK_FREQ / 100,
    parameter logic [7:0]  RESET_PATTERN = 8'h1F,
    parameter logic [7:0]  RESET_PERIOD  = 8'd99
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic [7:0] leds,
    output logic       running,
    output logic       step_pulse,
    output logic       cmd_err
);
    localparam int unsigned   PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    localparam logic [2:0] OP_NOP        = 3'd0;
    localparam logic [2:0] OP_LOAD       = 3'd1;
    localparam logic [2:0] OP_SET_PERIOD = 3'd2;
    localparam logic [2:0] OP_START      = 3'd3;
    localparam logic [2:0] OP_STOP       = 3'd4;
    localparam logic [2:0] OP_STEP       = 3'd5;

    localparam logic [1:0] MODE_ROT_L  = 2'd0;
    localparam logic [1:0] MODE_ROT_R  = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_RSVD   = 2'd3;

    typedef enum logic {ST_STOP, ST_RUN} state_t;

    state_t        state;
    logic [7:0]    period;
    logic [7:0]    per_cnt;
    logic [PW-1:0] presc;
    logic [1:0]    mode;
    logic          dir_right;

    logic       tick_last;
    logic       step_now;
    logic [7:0] rot_l;
    logic [7:0] rot_r;
    logic [7:0] step_leds;
    logic       step_dir;

    assign tick_last = (presc == PRESC_LAST);
    assign step_now  = (state == ST_RUN) && tick_last && (per_cnt == period);
    assign cmd_ready = !step_now;
    assign running   = (state == ST_RUN);

    // Next pattern and direction if a step happens this cycle.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        rot_l     = {leds[6:0], leds[7]};
        rot_r     = {leds[0], leds[7:1]};
        step_leds = rot_l;
        step_dir  = dir_right;
        case (mode)
            MODE_ROT_R: step_leds = rot_r;
            MODE_BOUNCE: begin
                if (!dir_right && leds[7]) begin
                    step_dir  = 1'b1;
                    step_leds = rot_r;
                end else if (dir_right && leds[0]) begin
                    step_dir  = 1'b0;
                    step_leds = rot_l;
                end else begin
                    step_leds = dir_right ? rot_r : rot_l;
                end
            end
            default: step_leds = rot_l;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state      <= ST_RUN;
            leds       <= RESET_PATTERN;
            period     <= RESET_PERIOD;
            mode       <= MODE_ROT_L;
            dir_right  <= 1'b0;
            presc      <= '0;
            per_cnt    <= '0;
            step_pulse <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            cmd_err    <= 1'b0;

            if (state == ST_RUN) begin
                if (tick_last) begin
                    presc   <= '0;
                    per_cnt <= per_cnt + 8'd1;
                end else begin
                    presc <= presc + 1'b1;
                end
            end

            // NOTE: a later non-blocking assignment to the same register wins,
            // so the clears below override the free-running count above.
            if (step_now) begin
                leds       <= step_leds;
                dir_right  <= step_dir;
                step_pulse <= 1'b1;
                per_cnt    <= '0;
            end else if (cmd_valid) begin
                case (cmd_op)
                    OP_NOP: ;
                    OP_LOAD: begin
                        leds    <= cmd_data;
                        presc   <= '0;
                        per_cnt <= '0;
                    end
                    OP_SET_PERIOD: begin
                        period  <= cmd_data;
                        presc   <= '0;
                        per_cnt <= '0;
                    end
                    OP_START: begin
                        if (cmd_data[1:0] == MODE_RSVD) begin
                            cmd_err <= 1'b1;
                        end else begin
                            mode      <= cmd_data[1:0];
                            dir_right <= 1'b0;
                            state     <= ST_RUN;
                            presc     <= '0;
                            per_cnt   <= '0;
                        end
                    end
                    OP_STOP: begin
                        state   <= ST_STOP;
                        presc   <= '0;
                        per_cnt <= '0;
                    end
                    OP_STEP: begin
                        // A manual step is only meaningful while stopped.
                        if (state == ST_STOP) begin
                            leds       <= step_leds;
                            dir_right  <= step_dir;
                            step_pulse <= 1'b1;
                        end
                    end
                    default: cmd_err <= 1'b1;
                endcase
            end
        end
    end

endmodule
